// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - two-flop synchronizer, debounce FSM, rise/fall pulses and glitch counter
// Feeds the D input of the single-bit tri-state flop from an asynchronous raw input.
module input_conditioner #(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_raw,
  input  logic                clr_glitch,
  output logic                d_clean,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          s1, s2;
  logic          glitch;

  // A glitch is any sample that disagrees with the level being qualified.
  always_comb begin
    glitch = 1'b0;
    if (state == CHK_HI && !s2) glitch = 1'b1;
    if (state == CHK_LO &&  s2) glitch = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= LOW;
      count      <= '0;
      d_clean    <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      s1   <= d_raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW: begin
          if (s2) begin
            state <= CHK_HI;
            count <= CW'(1);
          end
        end
        CHK_HI: begin
          if (s2) begin
            if (count == LAST) begin
              state   <= HIGH;
              count   <= '0;
              d_clean <= 1'b1;
              rise    <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end else begin
            state <= LOW;
            count <= '0;
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= CHK_LO;
            count <= CW'(1);
          end
        end
        CHK_LO: begin
          if (!s2) begin
            if (count == LAST) begin
              state   <= LOW;
              count   <= '0;
              d_clean <= 1'b0;
              fall    <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end else begin
            state <= HIGH;
            count <= '0;
          end
        end
        default: begin
          state <= LOW;
          count <= '0;
        end
      endcase
      // Clear takes priority over a coincident glitch.
      if (clr_glitch)
        glitch_cnt <= '0;
      else if (glitch && glitch_cnt != {GLITCH_W{1'b1}})
        glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream conditioning stage for the single-bit tri-state flip-flop: takes an asynchronous raw input and drives that flop's D.
- Synchronizes the raw input with a two-flop chain, then debounces it so the output changes only after STABLE_CYCLES consecutive identical samples.
- Emits one-cycle rise/fall pulses and a saturating count of rejected glitches for debug.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required to change d_clean; legal range ≥2.
- GLITCH_W, 8, width of glitch_cnt.

Ports:
- clk  input  1  system clock, all flops on posedge.
- rst  input  1  asynchronous, active-high reset.
- d_raw  input  1  asynchronous raw input signal.
- clr_glitch  input  1  synchronous clear of glitch_cnt.
- d_clean  output  1  debounced level; drives the flip-flop D input.
- rise  output  1  one-cycle pulse on a 0→1 change of d_clean.
- fall  output  1  one-cycle pulse on a 1→0 change of d_clean.
- glitch_cnt  output  GLITCH_W  saturating count of aborted transitions.

Behaviour:
- Reset (asynchronous, immediate on rst=1): sync flops s1,s2=0; state=LOW; internal count=0; d_clean=0, rise=0, fall=0, glitch_cnt=0.
- Synchronizer: s1<=d_raw, s2<=s1; d_sync=s2. d_raw is used nowhere else.
- Internal count width: $clog2(STABLE_CYCLES)+1 bits.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: LOW, CHK_HI, HIGH, CHK_LO. d_clean=1 in HIGH and CHK_LO, else 0.
- LOW: d_sync=1 → CHK_HI, count<=1; else hold.
- CHK_HI, d_sync=1: if count==STABLE_CYCLES-1 → HIGH, d_clean<=1, rise<=1; else count<=count+1.
- CHK_HI, d_sync=0 → LOW, count<=0, glitch event.
- HIGH: d_sync=0 → CHK_LO, count<=1; else hold.
- CHK_LO, d_sync=0: if count==STABLE_CYCLES-1 → LOW, d_clean<=0, fall<=1; else count<=count+1.
- CHK_LO, d_sync=1 → HIGH, count<=0, glitch event.
- rise/fall are high for exactly one cycle, coincident with the first cycle of the new d_clean level. They are never both high.
- Latency: d_raw changes and is stable before posedge k → d_clean changes after posedge k+STABLE_CYCLES+1 (5 edges at default).
- Minimum accepted pulse width on d_raw: STABLE_CYCLES cycles. Any shorter pulse produces exactly one glitch event and no d_clean change.
- glitch_cnt: +1 per glitch event; saturates at 2^GLITCH_W-1, no wrap.
- clr_glitch=1 → glitch_cnt<=0. Clear wins over a simultaneous glitch event (result 0).
- Reset mid-transition discards the partial count; no pulse is emitted.
- After reset release with d_raw=1, a normal LOW→HIGH qualification occurs and rise fires once.
- Multi-cycle d_raw oscillation faster than STABLE_CYCLES: one glitch event per abort. d_clean holds.

Test Plan:
- Reset: rst=1 with d_raw toggling → d_clean=0, rise=0, fall=0, glitch_cnt=0 throughout. Deassert with d_raw=0 → all outputs remain 0 for 10 cycles.
- Clean rise: d_raw 0→1 at negedge before posedge k, held → d_clean=1 after posedge k+5; rise=1 for exactly that one cycle; fall=0; glitch_cnt=0.
- Clean fall: from HIGH, d_raw 1→0 held 8 cycles → d_clean=0 after 5 edges; fall pulses once.
- Glitch rejection: d_raw high for 2 cycles then low → d_clean stays 0, glitch_cnt=1. Repeat with a 3-cycle low glitch from HIGH → d_clean stays 1, glitch_cnt=2.
- Saturation/clear (GLITCH_W=8): 300 two-cycle glitches → glitch_cnt=255. Assert clr_glitch in the same cycle as the next abort → glitch_cnt=0 next cycle.
- Async reset mid-CHK_HI: assert rst between posedges after 2 qualifying samples → outputs 0 before the next edge. Release with d_raw=1 → rise after 5 edges, single pulse.
